// File: rtl/axi4lite_uart_mux_bridge.sv
// AXI4-Lite slave that fans out byte-wide register accesses to NUM_CH UART register banks.
// AW, W and AR are each held independently; one transaction executes at a time.
module axi4lite_uart_mux_bridge #(
   parameter int NUM_CH             = 4,
   parameter int AXI4_ADDRESS_WIDTH = 8,
   parameter int AXI4_DATA_WIDTH    = 32
) (
   input  logic                            s_axi_aclk,
   input  logic                            s_axi_aresetn,
   input  logic                            s_axi_awvalid,
   input  logic [AXI4_ADDRESS_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   output logic                            s_axi_awready,
   input  logic                            s_axi_wvalid,
   input  logic [AXI4_DATA_WIDTH-1:0]      s_axi_wdata,
   input  logic [AXI4_DATA_WIDTH/8-1:0]    s_axi_wstrb,
   output logic                            s_axi_wready,
   output logic                            s_axi_bvalid,
   output logic [1:0]                      s_axi_bresp,
   input  logic                            s_axi_bready,
   input  logic                            s_axi_arvalid,
   input  logic [AXI4_ADDRESS_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   output logic                            s_axi_arready,
   output logic                            s_axi_rvalid,
   output logic [AXI4_DATA_WIDTH-1:0]      s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   input  logic                            s_axi_rready,
   output logic [2:0]                      reg_addr,
   output logic [7:0]                      reg_wdata,
   output logic [NUM_CH-1:0]               reg_we,
   output logic [NUM_CH-1:0]               reg_re,
   input  logic [NUM_CH*8-1:0]             reg_rdata,
   input  logic [NUM_CH-1:0]               reg_wr_err
);
   typedef enum logic [2:0] {IDLE, WR_EXEC, WR_CHK, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP} state_e;
   localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

   state_e                     state_q, state_d;
   logic                       aw_hold_q, w_hold_q, ar_hold_q;
   logic [5:0]                 aw_addr_q, ar_addr_q;   // addr[7:2] = {channel, offset}
   logic [7:0]                 w_data_q;
   logic                       w_strb0_q;
   logic                       last_wr_q;              // 1: last contested grant went to the write
   logic [1:0]                 bresp_q, rresp_q;
   logic [AXI4_DATA_WIDTH-1:0] rdata_q;

   logic aw_fire, w_fire, ar_fire, b_fire, r_fire;
   logic wr_pend, aw_mapped, ar_mapped, wr_issue, wr_err_sel;
   logic [7:0] rd_byte;
   logic unused_inputs;

   assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr,
                            s_axi_wdata, s_axi_wstrb};

   // Readies are forced low while reset is asserted, high once holds are empty.
   assign s_axi_awready = s_axi_aresetn & ~aw_hold_q;
   assign s_axi_wready  = s_axi_aresetn & ~w_hold_q;
   assign s_axi_arready = s_axi_aresetn & ~ar_hold_q;

   assign aw_fire   = s_axi_awvalid & s_axi_awready;
   assign w_fire    = s_axi_wvalid  & s_axi_wready;
   assign ar_fire   = s_axi_arvalid & s_axi_arready;
   assign b_fire    = (state_q == WR_RESP) & s_axi_bready;
   assign r_fire    = (state_q == RD_RESP) & s_axi_rready;
   assign wr_pend   = aw_hold_q & w_hold_q;
   assign aw_mapped = int'(aw_addr_q[5:3]) < NUM_CH;
   assign ar_mapped = int'(ar_addr_q[5:3]) < NUM_CH;
   assign wr_issue  = aw_mapped & w_strb0_q;

   always_comb begin
      wr_err_sel = 1'b0;
      rd_byte    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (aw_addr_q[5:3] == 3'(c)) wr_err_sel = reg_wr_err[c];
         if (ar_addr_q[5:3] == 3'(c)) rd_byte    = reg_rdata[8*c +: 8];
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         aw_hold_q <= 1'b0;
         aw_addr_q <= '0;
         w_hold_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb0_q <= 1'b0;
         ar_hold_q <= 1'b0;
         ar_addr_q <= '0;
      end else begin
         if (aw_fire) begin
            aw_hold_q <= 1'b1;
            aw_addr_q <= s_axi_awaddr[7:2];
         end else if (b_fire) begin
            aw_hold_q <= 1'b0;
         end
         if (w_fire) begin
            w_hold_q  <= 1'b1;
            w_data_q  <= s_axi_wdata[7:0];
            w_strb0_q <= s_axi_wstrb[0];
         end else if (b_fire) begin
            w_hold_q  <= 1'b0;
         end
         if (ar_fire) begin
            ar_hold_q <= 1'b1;
            ar_addr_q <= s_axi_araddr[7:2];
         end else if (r_fire) begin
            ar_hold_q <= 1'b0;
         end
      end
   end

   // State register; the grant flag only moves on contested grants so successive ties alternate.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q   <= IDLE;
         last_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && wr_pend && ar_hold_q) last_wr_q <= (state_d == WR_EXEC);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (wr_pend && (!ar_hold_q || !last_wr_q)) state_d = WR_EXEC;
            else if (ar_hold_q)                        state_d = RD_EXEC;
         end
         WR_EXEC: state_d = WR_CHK;
         WR_CHK:  state_d = WR_RESP;
         WR_RESP: if (s_axi_bready) state_d = IDLE;
         RD_EXEC: state_d = RD_WAIT;
         RD_WAIT: state_d = RD_RESP;
         RD_RESP: if (s_axi_rready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      reg_addr     = '0;
      reg_wdata    = '0;
      reg_we       = '0;
      reg_re       = '0;
      s_axi_bvalid = (state_q == WR_RESP);
      s_axi_rvalid = (state_q == RD_RESP);
      case (state_q)
         WR_EXEC: begin
            reg_addr  = aw_addr_q[2:0];
            reg_wdata = w_data_q;
            for (int c = 0; c < NUM_CH; c++) reg_we[c] = wr_issue && (aw_addr_q[5:3] == 3'(c));
         end
         RD_EXEC: begin
            reg_addr = ar_addr_q[2:0];
            for (int c = 0; c < NUM_CH; c++) reg_re[c] = ar_mapped && (ar_addr_q[5:3] == 3'(c));
         end
         default: ;
      endcase
   end

   // Response capture: write status one cycle after the pulse, read data one cycle after the strobe.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         bresp_q <= RESP_OKAY;
         rresp_q <= RESP_OKAY;
         rdata_q <= '0;
      end else begin
         if (state_q == WR_CHK) begin
            if (!aw_mapped)                   bresp_q <= RESP_DECERR;
            else if (wr_issue && wr_err_sel)  bresp_q <= RESP_SLVERR;
            else                              bresp_q <= RESP_OKAY;
         end
         if (state_q == RD_WAIT) begin
            rdata_q <= ar_mapped ? AXI4_DATA_WIDTH'(rd_byte) : '0;
            rresp_q <= ar_mapped ? RESP_OKAY : RESP_DECERR;
         end
      end
   end

   assign s_axi_bresp = bresp_q;
   assign s_axi_rresp = rresp_q;
   assign s_axi_rdata = rdata_q;

endmodule

// File: tb/tb_axi4lite_uart_mux_bridge.sv
// Self-checking bench: directed scenarios plus randomized traffic against a register-array model.
module tb_axi4lite_uart_mux_bridge;
   localparam int NUM_CH = 4;
   localparam int AW     = 8;
   localparam int DW     = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
   logic          s_axi_bready = 1'b0, s_axi_rready = 1'b0;
   logic [AW-1:0] s_axi_awaddr = '0, s_axi_araddr = '0;
   logic [DW-1:0] s_axi_wdata = '0;
   logic [3:0]    s_axi_wstrb = '0;
   logic          s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
   logic [1:0]    s_axi_bresp, s_axi_rresp;
   logic [DW-1:0] s_axi_rdata;
   logic [2:0]    reg_addr;
   logic [7:0]    reg_wdata;
   logic [NUM_CH-1:0]   reg_we, reg_re;
   logic [NUM_CH*8-1:0] reg_rdata;
   logic [NUM_CH-1:0]   err_mask = '0;

   axi4lite_uart_mux_bridge #(.NUM_CH(NUM_CH), .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(3'b000),
      .s_axi_awready(s_axi_awready),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wready(s_axi_wready),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp), .s_axi_bready(s_axi_bready),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_araddr(s_axi_araddr), .s_axi_arprot(3'b000),
      .s_axi_arready(s_axi_arready),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rready(s_axi_rready),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .reg_wr_err(err_mask)
   );

   // Peripheral: 8 byte registers per channel; rejected writes leave the register untouched,
   // read data appears the cycle after the read strobe.
   logic [7:0] periph [NUM_CH][8];
   logic [7:0] rd_hold [NUM_CH];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            rd_hold[c] <= '0;
            for (int r = 0; r < 8; r++) periph[c][r] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (reg_we[c] && !err_mask[c]) periph[c][reg_addr] <= reg_wdata;
            if (reg_re[c]) rd_hold[c] <= periph[c][reg_addr];
         end
      end
   end
   always_comb begin
      reg_rdata = '0;
      for (int c = 0; c < NUM_CH; c++) reg_rdata[8*c +: 8] = rd_hold[c];
   end

   // Strobe monitor: totals, last pulse contents, and protocol violations.
   int unsigned we_total = 0, re_total = 0, viol = 0;
   logic [NUM_CH-1:0] last_we_vec = '0, prev_we = '0, prev_re = '0;
   logic [7:0] last_wdata = '0;
   logic [2:0] last_waddr = '0;
   always @(negedge clk) begin
      if ($countones(reg_we) > 1 || $countones(reg_re) > 1 || (reg_we != 0 && reg_re != 0) ||
          (prev_we != 0 && reg_we != 0) || (prev_re != 0 && reg_re != 0)) viol = viol + 1;
      if (reg_we != 0) begin
         we_total    = we_total + 1;
         last_we_vec = reg_we;
         last_wdata  = reg_wdata;
         last_waddr  = reg_addr;
      end
      if (reg_re != 0) re_total = re_total + 1;
      prev_we = reg_we;
      prev_re = reg_re;
   end

   int n_cmp = 0, n_err = 0;
   int unsigned mreg [NUM_CH][8];

   function automatic int ch_of(input logic [7:0] a);
      return int'(a) / 32;
   endfunction
   function automatic int off_of(input logic [7:0] a);
      return (int'(a) % 32) / 4;
   endfunction

   task automatic apply_reset();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      rst_n = 1'b0;
      for (int c = 0; c < NUM_CH; c++) for (int r = 0; r < 8; r++) mreg[c][r] = 0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Presents the selected channels together and drops each valid after its handshake edge.
   task automatic issue(input bit do_aw, input bit do_w, input bit do_ar, input logic [7:0] waddr,
                        input logic [31:0] wdata, input logic [3:0] wstrb, input logic [7:0] raddr);
      int n;
      logic aw_hs, w_hs, ar_hs;
      s_axi_awvalid = do_aw; s_axi_awaddr = waddr;
      s_axi_wvalid = do_w; s_axi_wdata = wdata; s_axi_wstrb = wstrb;
      s_axi_arvalid = do_ar; s_axi_araddr = raddr;
      n = 0;
      while ((s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) && n < 200) begin
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         ar_hs = s_axi_arvalid && s_axi_arready;
         @(posedge clk);
         #1;
         if (aw_hs) s_axi_awvalid = 1'b0;
         if (w_hs)  s_axi_wvalid = 1'b0;
         if (ar_hs) s_axi_arvalid = 1'b0;
         n++;
      end
      if (n >= 200) begin
         $display("FAIL issue_timeout: handshake still pending after %0d cycles, required completion", n);
         n_err++; n_cmp++;
         s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      end
   endtask

   task automatic wait_b(input int dly, output logic [1:0] resp, output int lat);
      lat = 0;
      resp = 2'bxx;
      while (!s_axi_bvalid && lat < 100) begin @(posedge clk); #1; lat++; end
      if (!s_axi_bvalid) begin
         $display("FAIL bvalid_timeout: bvalid=0 after %0d cycles, required 1", lat);
         n_err++; n_cmp++;
      end else begin
         resp = s_axi_bresp;
         repeat (dly) begin @(posedge clk); #1; end
         s_axi_bready = 1'b1;
         @(posedge clk);
         #1;
         s_axi_bready = 1'b0;
      end
   endtask

   task automatic wait_r(input int dly, output logic [31:0] data, output logic [1:0] resp, output int lat);
      lat = 0;
      data = 'x;
      resp = 2'bxx;
      while (!s_axi_rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
      if (!s_axi_rvalid) begin
         $display("FAIL rvalid_timeout: rvalid=0 after %0d cycles, required 1", lat);
         n_err++; n_cmp++;
      end else begin
         data = s_axi_rdata;
         resp = s_axi_rresp;
         repeat (dly) begin @(posedge clk); #1; end
         s_axi_rready = 1'b1;
         @(posedge clk);
         #1;
         s_axi_rready = 1'b0;
      end
   endtask

   task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] strb);
      if (ch_of(a) < NUM_CH && strb[0] && !err_mask[ch_of(a)]) mreg[ch_of(a)][off_of(a)] = d % 256;
   endtask

   task automatic test_reset();
      apply_reset();
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
         $display("FAIL reset_ready: got %b, required 000", {s_axi_awready, s_axi_wready, s_axi_arready}); n_err++; end
      n_cmp++;
      if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp} !== 6'd0 || s_axi_rdata !== 32'd0) begin
         $display("FAIL reset_resp: got b/r=%b rdata=%h, required zeros",
                  {s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp}, s_axi_rdata); n_err++; end
      n_cmp++;
      if ({reg_we, reg_re, reg_addr, reg_wdata} !== '0) begin
         $display("FAIL reset_reg_if: got %h, required 0", {reg_we, reg_re, reg_addr, reg_wdata}); n_err++; end
      n_cmp++;
      release_reset();
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
         $display("FAIL post_reset_ready: got %b, required 111", {s_axi_awready, s_axi_wready, s_axi_arready}); n_err++; end
      n_cmp++;
   endtask

   task automatic test_basic_rw();
      logic [1:0] resp; logic [31:0] data; int lat; int unsigned we0, re0;
      we0 = we_total;
      issue(1, 1, 0, 8'h20, 32'hDEAD_BE41, 4'hF, 8'h00);
      model_write(8'h20, 32'hDEAD_BE41, 4'hF);
      wait_b(0, resp, lat);
      if (lat !== 3) begin $display("FAIL wr_latency: got %0d, required 3", lat); n_err++; end
      n_cmp++;
      if (resp !== 2'b00) begin $display("FAIL wr_bresp: got %b, required 00", resp); n_err++; end
      n_cmp++;
      if (we_total - we0 !== 1 || last_we_vec !== 4'b0010 || last_wdata !== 8'h41 || last_waddr !== 3'd0) begin
         $display("FAIL wr_pulse: got n=%0d vec=%b data=%h off=%0d, required n=1 vec=0010 data=41 off=0",
                  we_total - we0, last_we_vec, last_wdata, last_waddr); n_err++; end
      n_cmp++;
      issue(1, 1, 0, 8'h4C, 32'h0000_0003, 4'h1, 8'h00);
      model_write(8'h4C, 32'h3, 4'h1);
      wait_b(1, resp, lat);
      re0 = re_total;
      issue(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h4C);
      wait_r(0, data, resp, lat);
      if (lat !== 3) begin $display("FAIL rd_latency: got %0d, required 3", lat); n_err++; end
      n_cmp++;
      if (data !== mreg[2][3] || data !== 32'h3 || resp !== 2'b00) begin
         $display("FAIL rd_ch2_off3: got data=%h resp=%b, required 00000003/00", data, resp); n_err++; end
      n_cmp++;
      if (re_total - re0 !== 1) begin $display("FAIL rd_pulse: got %0d pulses, required 1", re_total - re0); n_err++; end
      n_cmp++;
   endtask

   task automatic test_unmapped();
      logic [1:0] resp; logic [31:0] data; int lat; int unsigned we0, re0;
      we0 = we_total; re0 = re_total;
      issue(1, 1, 0, 8'hA0, 32'h77, 4'hF, 8'h00);
      wait_b(0, resp, lat);
      if (resp !== 2'b11 || we_total !== we0) begin
         $display("FAIL unmapped_wr: got bresp=%b pulses=%0d, required 11/0", resp, we_total - we0); n_err++; end
      n_cmp++;
      issue(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'hE4);
      wait_r(0, data, resp, lat);
      if (data !== 32'h0 || resp !== 2'b11 || re_total !== re0) begin
         $display("FAIL unmapped_rd: got data=%h rresp=%b pulses=%0d, required 0/11/0", data, resp, re_total - re0); n_err++; end
      n_cmp++;
   endtask

   task automatic test_wr_err_and_order();
      logic [1:0] resp; int lat; int unsigned we0; logic ok;
      err_mask = 4'b0001;
      issue(1, 1, 0, 8'h04, 32'h11, 4'h1, 8'h00);
      wait_b(0, resp, lat);
      if (resp !== 2'b10) begin $display("FAIL wr_err_bresp: got %b, required 10", resp); n_err++; end
      n_cmp++;
      issue(0, 1, 0, 8'h00, 32'h22, 4'h1, 8'h00);
      ok = 1'b1;
      repeat (5) begin
         if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0) ok = 1'b0;
         @(posedge clk); #1;
      end
      if (ok !== 1'b1) begin $display("FAIL w_first_hold: got wready/bvalid activity, required wready=0 bvalid=0"); n_err++; end
      n_cmp++;
      issue(1, 0, 0, 8'h00, 32'h0, 4'h0, 8'h00);
      wait_b(0, resp, lat);
      if (resp !== 2'b10 || lat !== 3) begin
         $display("FAIL w_first_bresp: got %b lat=%0d, required 10 lat=3", resp, lat); n_err++; end
      n_cmp++;
      err_mask = 4'b0000;
      we0 = we_total;
      issue(1, 1, 0, 8'h28, 32'h99, 4'hE, 8'h00);
      model_write(8'h28, 32'h99, 4'hE);
      wait_b(0, resp, lat);
      if (resp !== 2'b00 || we_total !== we0) begin
         $display("FAIL strb0_low: got bresp=%b pulses=%0d, required 00/0", resp, we_total - we0); n_err++; end
      n_cmp++;
   endtask

   task automatic test_back_to_back();
      logic [1:0] resp, b0; logic [31:0] data; int lat, n; logic ok;
      apply_reset();
      release_reset();
      issue(1, 1, 1, 8'h24, 32'h55, 4'h1, 8'h24);
      n = 0;
      while (!s_axi_bvalid && !s_axi_rvalid && n < 100) begin @(posedge clk); #1; n++; end
      if ({s_axi_bvalid, s_axi_rvalid} !== 2'b10) begin
         $display("FAIL tie1_order: got b/r=%b, required 10 (write first)", {s_axi_bvalid, s_axi_rvalid}); n_err++; end
      n_cmp++;
      b0 = s_axi_bresp; ok = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== b0 || s_axi_rvalid !== 1'b0) ok = 1'b0;
      end
      if (ok !== 1'b1) begin $display("FAIL bvalid_stable: got change while bready=0, required stable"); n_err++; end
      n_cmp++;
      wait_b(0, resp, lat);
      model_write(8'h24, 32'h55, 4'h1);
      wait_r(0, data, resp, lat);
      if (data !== mreg[1][1] || data !== 32'h55) begin
         $display("FAIL tie1_read: got %h, required 00000055", data); n_err++; end
      n_cmp++;
      issue(1, 1, 1, 8'h24, 32'hAA, 4'h1, 8'h24);
      n = 0;
      while (!s_axi_bvalid && !s_axi_rvalid && n < 100) begin @(posedge clk); #1; n++; end
      if ({s_axi_bvalid, s_axi_rvalid} !== 2'b01) begin
         $display("FAIL tie2_order: got b/r=%b, required 01 (read first)", {s_axi_bvalid, s_axi_rvalid}); n_err++; end
      n_cmp++;
      wait_r(0, data, resp, lat);
      if (data !== 32'h55) begin $display("FAIL tie2_read: got %h, required 00000055", data); n_err++; end
      n_cmp++;
      wait_b(0, resp, lat);
      model_write(8'h24, 32'hAA, 4'h1);
   endtask

   task automatic test_reset_mid_read();
      logic [1:0] resp; logic [31:0] data; int lat; int unsigned re0; logic ok;
      issue(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h4C);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      re0 = re_total;
      if ({s_axi_rvalid, s_axi_rresp, s_axi_awready, s_axi_arready} !== 5'd0 || s_axi_rdata !== 32'd0 ||
          {reg_we, reg_re, reg_addr, reg_wdata} !== '0) begin
         $display("FAIL mid_reset_outputs: got rvalid=%b rdata=%h reg_if=%h, required zeros",
                  s_axi_rvalid, s_axi_rdata, {reg_we, reg_re, reg_addr, reg_wdata}); n_err++; end
      n_cmp++;
      for (int c = 0; c < NUM_CH; c++) for (int r = 0; r < 8; r++) mreg[c][r] = 0;
      repeat (2) @(posedge clk);
      release_reset();
      ok = 1'b1;
      repeat (10) begin if (s_axi_rvalid !== 1'b0) ok = 1'b0; @(posedge clk); #1; end
      if (ok !== 1'b1 || re_total !== re0) begin
         $display("FAIL abandoned_read: got late rvalid or %0d strobes, required none", re_total - re0); n_err++; end
      n_cmp++;
      issue(1, 1, 0, 8'h4C, 32'h5A, 4'h1, 8'h00);
      model_write(8'h4C, 32'h5A, 4'h1);
      wait_b(0, resp, lat);
      issue(0, 0, 1, 8'h00, 32'h0, 4'h0, 8'h4C);
      wait_r(0, data, resp, lat);
      if (data !== mreg[2][3] || resp !== 2'b00 || lat !== 3) begin
         $display("FAIL post_reset_read: got %h/%b lat=%0d, required %h/00 lat=3", data, resp, lat, mreg[2][3]); n_err++; end
      n_cmp++;
   endtask

   task automatic test_random();
      logic [7:0] a; logic [31:0] d, data; logic [3:0] strb; logic [1:0] resp, er; int lat, ch;
      int unsigned we0, re0, ew; logic [31:0] ed;
      for (int i = 0; i < 80; i++) begin
         a = 8'($urandom_range(0, 255)); d = $urandom; strb = 4'($urandom);
         err_mask = NUM_CH'($urandom);
         ch = ch_of(a);
         we0 = we_total; re0 = re_total;
         if ($urandom_range(0, 1) == 1) begin
            if (ch >= NUM_CH) er = 2'b11; else if (strb[0] && err_mask[ch]) er = 2'b10; else er = 2'b00;
            ew = (ch < NUM_CH && strb[0]) ? 1 : 0;
            issue(1, 1, 0, a, d, strb, 8'h00);
            model_write(a, d, strb);
            wait_b($urandom_range(0, 3), resp, lat);
            if (resp !== er || lat !== 3 || we_total - we0 !== ew) begin
               $display("FAIL rand_wr[%0d] a=%h: got resp=%b lat=%0d pulses=%0d, required %b/3/%0d",
                        i, a, resp, lat, we_total - we0, er, ew); n_err++; end
            n_cmp++;
         end else begin
            ed = (ch < NUM_CH) ? mreg[ch][off_of(a)] : 0;
            er = (ch < NUM_CH) ? 2'b00 : 2'b11;
            issue(0, 0, 1, 8'h00, 32'h0, 4'h0, a);
            wait_r($urandom_range(0, 3), data, resp, lat);
            if (data !== ed || resp !== er || lat !== 3 || re_total - re0 !== ((ch < NUM_CH) ? 1 : 0)) begin
               $display("FAIL rand_rd[%0d] a=%h: got %h/%b lat=%0d, required %h/%b lat=3",
                        i, a, data, resp, lat, ed, er); n_err++; end
            n_cmp++;
         end
      end
      if (viol !== 0) begin $display("FAIL strobe_protocol: got %0d violations, required 0", viol); n_err++; end
      n_cmp++;
   endtask

   initial begin
      test_reset();
      test_basic_rw();
      test_unmapped();
      test_wr_err_and_order();
      test_back_to_back();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi4lite_uart_mux_bridge.md
AXI4LITE_UART_MUX_BRIDGE -- requirements
Module: axi4lite_uart_mux_bridge

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4 (1..8): number of UART register-bank channels served.
REQ-002 SHALL provide parameter AXI4_ADDRESS_WIDTH, default 8 (>=8): byte address width.
REQ-003 SHALL provide parameter AXI4_DATA_WIDTH, default 32: AXI data width; WSTRB width is AXI4_DATA_WIDTH/8.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: s_axi_aclk  in  1  clock; s_axi_aresetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have s_axi_awvalid in 1, s_axi_awaddr in AXI4_ADDRESS_WIDTH, s_axi_awprot in 3 (ignored), s_axi_awready out 1: write address channel.
REQ-006 SHALL have s_axi_wvalid in 1, s_axi_wdata in AXI4_DATA_WIDTH, s_axi_wstrb in AXI4_DATA_WIDTH/8, s_axi_wready out 1: write data channel.
REQ-007 SHALL have s_axi_bvalid out 1, s_axi_bresp out 2, s_axi_bready in 1: write response channel.
REQ-008 SHALL have s_axi_arvalid in 1, s_axi_araddr in AXI4_ADDRESS_WIDTH, s_axi_arprot in 3 (ignored), s_axi_arready out 1: read address channel.
REQ-009 SHALL have s_axi_rvalid out 1, s_axi_rdata out AXI4_DATA_WIDTH, s_axi_rresp out 2, s_axi_rready in 1: read data channel.
REQ-010 SHALL have reg_addr out 3 (register offset), reg_wdata out 8, reg_we out NUM_CH (one-hot write pulse), reg_re out NUM_CH (one-hot read pulse).
REQ-011 SHALL have reg_rdata in NUM_CH*8 (channel c at bits [8c+7:8c]) and reg_wr_err in NUM_CH (per-channel write-rejected flag, e.g. TX FIFO overrun).

Function
REQ-012 Address decode: reg offset = addr[4:2]; channel = addr[7:5]; channel >= NUM_CH is unmapped; addr[1:0] and bits above 7 ignored.
REQ-013 AW, W, AR each latched into an independent hold register; awready = !aw_hold, wready = !w_hold, arready = !ar_hold; AW and W may complete in either order or the same cycle.
REQ-014 FSM states: IDLE, WR_EXEC, WR_CHK, WR_RESP, RD_EXEC, RD_WAIT, RD_RESP.
REQ-015 IDLE: aw_hold&&w_hold only -> WR_EXEC; ar_hold only -> RD_EXEC; both pending -> grant the type not granted last (last_grant flag, reset = read, so write wins first tie).
REQ-016 WR_EXEC (1 cycle): reg_addr/reg_wdata = offset/wdata[7:0]; reg_we[ch] high iff channel mapped and wstrb[0]=1; -> WR_CHK.
REQ-017 WR_CHK (1 cycle): bresp = 2'b11 (DECERR) if unmapped; else 2'b10 (SLVERR) if we was issued and reg_wr_err[ch]=1; else 2'b00; -> WR_RESP.
REQ-018 WR_RESP: bvalid=1 held stable until bready; on handshake clear aw_hold, w_hold, -> IDLE.
REQ-019 wstrb[0]=0 to mapped channel: no reg_we pulse, bresp OKAY.
REQ-020 RD_EXEC (1 cycle): reg_addr = offset; reg_re[ch] high iff mapped; -> RD_WAIT.
REQ-021 RD_WAIT: capture rdata = {zeros, reg_rdata[ch]} (unmapped: all zero, rresp DECERR; else OKAY); -> RD_RESP.
REQ-022 RD_RESP: rvalid=1, rdata/rresp stable until rready; on handshake clear ar_hold, -> IDLE.
REQ-023 Latency: bvalid/rvalid assert 3 cycles after edge completing the last address/data handshake when IDLE and no competing request.
REQ-024 reg_we/reg_re SHALL never exceed one-cycle pulse per transaction and never both high in one cycle; all bits zero outside WR_EXEC/RD_EXEC.
REQ-025 New AW/W/AR SHALL be accepted into empty holds while another transaction executes; at most one outstanding per channel type.

Reset
REQ-026 s_axi_aresetn low asynchronously forces: state IDLE, all holds clear, last_grant = read, awready/wready/arready = 0 while in reset then 1 after release, bvalid/rvalid = 0, bresp/rresp/rdata = 0, reg_we/reg_re = 0, reg_addr/reg_wdata = 0.
REQ-027 Reset mid-transaction SHALL abandon it with no response and no further reg_we/reg_re pulse.

Verification
REQ-028 Write 0x41 to addr 0x20 (ch1, off0), reg_wr_err=0 -> single reg_we=4'b0010 pulse, reg_wdata=0x41, bresp=00, bvalid 3 cycles after handshake.
REQ-029 Read addr 0x4C (ch2, off3), reg_rdata ch2=0x03 -> reg_re=4'b0100 once, rdata=0x00000003, rresp=00.
REQ-030 Write to 0xA0 with NUM_CH=4 -> no reg_we, bresp=11; read 0xE4 -> no reg_re, rdata=0, rresp=11.
REQ-031 Write with reg_wr_err[0]=1 during WR_CHK -> bresp=10; W before AW by 5 cycles -> same result, wready low meanwhile.
REQ-032 AW+W+AR presented same cycle after reset -> write executes first, read second; repeat -> read first; bready held low 10 cycles -> bvalid/bresp stable.
REQ-033 Assert s_axi_aresetn low during RD_WAIT -> rvalid never asserts, all outputs at reset values, next read completes normally.
